// File: rtl/adc_defs.sv
// Shared state encoding and default constants for the ADC sampling sequencer.
package adc_defs;

   typedef enum logic [1:0] {
      REPOSO    = 2'd0,
      SOLICITAR = 2'd1,
      CERRAR    = 2'd2
   } estado_t;

   localparam int unsigned ANCHO_DATO_DEF   = 4;
   localparam int unsigned DIV_MUESTREO_DEF = 2268;
   localparam int unsigned N_PROM_LOG2_DEF  = 2;
   localparam int unsigned TIMEOUT_DEF      = 4096;

   // Bits needed to count 0..n-1.
   function automatic int unsigned ancho_para(input int unsigned n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/divisor_muestreo.sv
// Sample-rate tick generator: one-cycle tick every DIV cycles while enabled.
module divisor_muestreo
   import adc_defs::*;
#(
   parameter int unsigned DIV = DIV_MUESTREO_DEF
) (
   input  logic clk100MHz,
   input  logic reset,
   input  logic habilitar,
   output logic tick
);

   localparam int unsigned   W        = ancho_para(DIV);
   localparam logic [W-1:0]  TERMINAL = W'(DIV - 1);

   logic [W-1:0] cuenta;

   always_ff @(posedge clk100MHz or negedge reset) begin
      if (!reset)
         cuenta <= '0;
      else if (!habilitar || cuenta == TERMINAL)
         cuenta <= '0;
      else
         cuenta <= cuenta + W'(1);
   end

   assign tick = habilitar && (cuenta == TERMINAL);

endmodule

// File: rtl/adc_secuenciador.sv
// Sampling controller: requests conversions on each tick, averages
// 2^N_PROM_LOG2 samples, flags timeouts and counts lost ticks.
module adc_secuenciador
   import adc_defs::*;
#(
   parameter int unsigned ANCHO_DATO   = ANCHO_DATO_DEF,
   parameter int unsigned DIV_MUESTREO = DIV_MUESTREO_DEF,
   parameter int unsigned N_PROM_LOG2  = N_PROM_LOG2_DEF,
   parameter int unsigned TIMEOUT      = TIMEOUT_DEF
) (
   input  logic                  clk100MHz,
   input  logic                  reset,
   input  logic                  habilitar,
   input  logic                  listo,
   input  logic [ANCHO_DATO-1:0] dato_adc,
   input  logic                  limpiar_error,
   output logic                  inicio,
   output logic [ANCHO_DATO-1:0] promedio,
   output logic                  promedio_valido,
   output logic                  ocupado,
   output logic                  error_timeout,
   output logic [7:0]            contador_perdidas
);

   localparam int unsigned ANCHO_ACC = ANCHO_DATO + N_PROM_LOG2;
   localparam int unsigned ANCHO_CNT = N_PROM_LOG2 + 1;
   localparam int unsigned ANCHO_TO  = ancho_para(TIMEOUT);

   localparam logic [ANCHO_CNT-1:0] N_MUESTRAS = ANCHO_CNT'(1 << N_PROM_LOG2);
   localparam logic [ANCHO_TO-1:0]  TO_FINAL   = ANCHO_TO'(TIMEOUT - 1);

   estado_t               estado;
   logic                  tick;
   logic                  listo_r;
   logic                  listo_sub_r;
   logic [ANCHO_DATO-1:0] dato_r;
   logic [ANCHO_ACC-1:0]  acc;
   logic [ANCHO_CNT-1:0]  cnt;
   logic [ANCHO_TO-1:0]   t_cnt;

   divisor_muestreo #(
      .DIV (DIV_MUESTREO)
   ) u_divisor (
      .clk100MHz (clk100MHz),
      .reset     (reset),
      .habilitar (habilitar),
      .tick      (tick)
   );

   // Edge pulse and sample are registered together, so the FSM acts one
   // cycle after listo is first sampled and a one-cycle listo still works.
   always_ff @(posedge clk100MHz or negedge reset) begin
      if (!reset) begin
         listo_r     <= 1'b0;
         listo_sub_r <= 1'b0;
         dato_r      <= '0;
      end else begin
         listo_r     <= listo;
         listo_sub_r <= listo & ~listo_r;
         dato_r      <= dato_adc;
      end
   end

   always_ff @(posedge clk100MHz or negedge reset) begin
      if (!reset) begin
         estado            <= REPOSO;
         inicio            <= 1'b0;
         promedio          <= '0;
         promedio_valido   <= 1'b0;
         error_timeout     <= 1'b0;
         contador_perdidas <= '0;
         acc               <= '0;
         cnt               <= '0;
         t_cnt             <= '0;
      end else begin
         promedio_valido <= 1'b0;
         if (limpiar_error)
            error_timeout <= 1'b0;
         if (tick && estado != REPOSO && contador_perdidas != 8'hFF)
            contador_perdidas <= contador_perdidas + 8'd1;

         case (estado)
            REPOSO: begin
               if (!habilitar) begin
                  acc <= '0;
                  cnt <= '0;
               end
               if (tick) begin
                  estado <= SOLICITAR;
                  inicio <= 1'b1;
                  t_cnt  <= '0;
               end
            end
            SOLICITAR: begin
               t_cnt <= t_cnt + ANCHO_TO'(1);
               if (listo_sub_r) begin
                  acc    <= acc + ANCHO_ACC'(dato_r);
                  cnt    <= cnt + ANCHO_CNT'(1);
                  inicio <= 1'b0;
                  estado <= CERRAR;
               end else if (t_cnt == TO_FINAL) begin
                  error_timeout <= 1'b1;
                  inicio        <= 1'b0;
                  estado        <= REPOSO;
               end
            end
            CERRAR: begin
               inicio <= 1'b0;
               if (cnt == N_MUESTRAS) begin
                  promedio        <= acc[ANCHO_ACC-1:N_PROM_LOG2];
                  promedio_valido <= 1'b1;
                  acc             <= '0;
                  cnt             <= '0;
               end
               estado <= REPOSO;
            end
            default: estado <= REPOSO;
         endcase
      end
   end

   assign ocupado = (estado != REPOSO);

endmodule

// File: tb/tb_adc_secuenciador.sv
// Scoreboard bench for adc_secuenciador: ADC response models, expected averages queued per run.
module tb_adc_secuenciador;

   logic       clk = 1'b0;
   int         cyc = 0;
   int         checks = 0;
   int         failures = 0;

   // DUT A: DIV_MUESTREO=20, N_PROM_LOG2=2, TIMEOUT=16
   logic       rst_a, hab_a, listo_a, limp_a;
   logic [3:0] dato_a;
   logic       inicio_a, pv_a, ocup_a, err_a;
   logic [3:0] prom_a;
   logic [7:0] perd_a;

   // DUT B: same but TIMEOUT=64, slow ADC
   logic       rst_b, hab_b, listo_b, limp_b;
   logic [3:0] dato_b;
   logic       inicio_b, pv_b, ocup_b, err_b;
   logic [3:0] prom_b;
   logic [7:0] perd_b;

   int  datos_a[$];
   int  esperado_a[$];
   bit  responde_a = 1'b1;
   int  n_listo_a = 0;
   int  last_k_a = 0;
   int  last_drop_a = 0;

   adc_secuenciador #(
      .ANCHO_DATO   (4),
      .DIV_MUESTREO (20),
      .N_PROM_LOG2  (2),
      .TIMEOUT      (16)
   ) dut (
      .clk100MHz         (clk),
      .reset             (rst_a),
      .habilitar         (hab_a),
      .listo             (listo_a),
      .dato_adc          (dato_a),
      .limpiar_error     (limp_a),
      .inicio            (inicio_a),
      .promedio          (prom_a),
      .promedio_valido   (pv_a),
      .ocupado           (ocup_a),
      .error_timeout     (err_a),
      .contador_perdidas (perd_a)
   );

   adc_secuenciador #(
      .ANCHO_DATO   (4),
      .DIV_MUESTREO (20),
      .N_PROM_LOG2  (2),
      .TIMEOUT      (64)
   ) dut_b (
      .clk100MHz         (clk),
      .reset             (rst_b),
      .habilitar         (hab_b),
      .listo             (listo_b),
      .dato_adc          (dato_b),
      .limpiar_error     (limp_b),
      .inicio            (inicio_b),
      .promedio          (prom_b),
      .promedio_valido   (pv_b),
      .ocupado           (ocup_b),
      .error_timeout     (err_b),
      .contador_perdidas (perd_b)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // ADC model A: listo three edges after inicio seen, held until inicio drops.
   initial begin
      listo_a = 1'b0;
      dato_a  = '0;
      forever begin
         @(posedge clk); #1;
         if (inicio_a === 1'b1 && responde_a) begin
            repeat (3) @(posedge clk);
            #1;
            if (inicio_a === 1'b1) begin
               if (datos_a.size() > 0) dato_a = 4'(datos_a.pop_front());
               else                    dato_a = 4'd0;
               listo_a   = 1'b1;
               n_listo_a = n_listo_a + 1;
               last_k_a  = cyc + 1;
               for (int i = 0; i < 50 && inicio_a === 1'b1; i++) begin
                  @(posedge clk); #1;
               end
               last_drop_a = cyc;
               listo_a     = 1'b0;
            end
         end
      end
   end

   // ADC model B: listo thirty edges after inicio seen.
   initial begin
      listo_b = 1'b0;
      dato_b  = 4'd5;
      forever begin
         @(posedge clk); #1;
         if (inicio_b === 1'b1) begin
            repeat (30) @(posedge clk);
            #1;
            if (inicio_b === 1'b1) begin
               listo_b = 1'b1;
               for (int j = 0; j < 80 && inicio_b === 1'b1; j++) begin
                  @(posedge clk); #1;
               end
               listo_b = 1'b0;
            end
         end
      end
   end

   task automatic esperar_valido_a(input int limite, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < limite; i++) begin
         @(negedge clk);
         if (pv_a === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      bit visto;
      rst_a = 1'b0; hab_a = 1'b0; limp_a = 1'b0;
      rst_b = 1'b0; hab_b = 1'b0; limp_b = 1'b0;
      repeat (5) @(posedge clk);
      @(negedge clk);
      checks++;
      if ({inicio_a, pv_a, ocup_a, err_a} !== 4'b0 || prom_a !== 4'd0 || perd_a !== 8'd0) begin
         failures++;
         $display("FAIL reset_state_a: got inicio=%b valido=%b ocupado=%b err=%b prom=%0d perd=%0d, want all 0",
                  inicio_a, pv_a, ocup_a, err_a, prom_a, perd_a);
      end
      checks++;
      if ({inicio_b, pv_b, ocup_b, err_b} !== 4'b0 || prom_b !== 4'd0 || perd_b !== 8'd0) begin
         failures++;
         $display("FAIL reset_state_b: got inicio=%b valido=%b ocupado=%b err=%b prom=%0d perd=%0d, want all 0",
                  inicio_b, pv_b, ocup_b, err_b, prom_b, perd_b);
      end
      rst_a = 1'b1;
      rst_b = 1'b1;
      visto = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (inicio_a !== 1'b0 || ocup_a !== 1'b0) visto = 1'b1;
      end
      checks++;
      if (visto !== 1'b0) begin
         failures++;
         $display("FAIL idle_disabled: inicio/ocupado seen high=%b, want 0", visto);
      end
   endtask

   task automatic test_promedio();
      bit ok;
      int exp_v;
      datos_a = '{8, 8, 9, 9};
      esperado_a.push_back(8);
      hab_a = 1'b1;
      esperar_valido_a(400, ok);
      hab_a = 1'b0;
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL avg_8899_wait: no promedio_valido within 400 cycles, want one");
      end else begin
         exp_v = esperado_a.pop_front();
         checks++;
         if (prom_a !== 4'(exp_v)) begin
            failures++;
            $display("FAIL avg_8899: promedio=%0d, want %0d", prom_a, exp_v);
         end
         checks++;
         if (cyc - last_k_a != 2) begin
            failures++;
            $display("FAIL avg_latency: valid at edge k+%0d, want k+2", cyc - last_k_a);
         end
         checks++;
         if (last_drop_a - last_k_a != 1) begin
            failures++;
            $display("FAIL inicio_drop: inicio low at edge k+%0d, want k+1", last_drop_a - last_k_a);
         end
      end
      @(negedge clk);
      checks++;
      if (pv_a !== 1'b0) begin
         failures++;
         $display("FAIL valid_one_cycle: promedio_valido=%b one cycle later, want 0", pv_a);
      end
      repeat (40) @(negedge clk);
   endtask

   task automatic test_saturacion();
      bit ok;
      int exp_v;
      datos_a = '{15, 15, 15, 15, 1, 2, 3, 6};
      esperado_a.push_back(15);
      esperado_a.push_back(3);
      hab_a = 1'b1;
      for (int n = 0; n < 2; n++) begin
         esperar_valido_a(400, ok);
         checks++;
         if (!ok) begin
            failures++;
            $display("FAIL avg_full_wait%0d: no promedio_valido within 400 cycles, want one", n);
         end else begin
            exp_v = esperado_a.pop_front();
            checks++;
            if (prom_a !== 4'(exp_v)) begin
               failures++;
               $display("FAIL avg_full%0d: promedio=%0d, want %0d", n, prom_a, exp_v);
            end
         end
      end
      hab_a = 1'b0;
      repeat (40) @(negedge clk);
   endtask

   task automatic test_timeout();
      bit ok;
      int n;
      responde_a = 1'b0;
      hab_a = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 60 && !ok; i++) begin
         @(negedge clk);
         if (inicio_a === 1'b1) ok = 1'b1;
      end
      n = 0;
      while (inicio_a === 1'b1 && n < 100) begin
         n++;
         @(negedge clk);
      end
      checks++;
      if (!ok || n != 16) begin
         failures++;
         $display("FAIL timeout_len: inicio high %0d cycles (started=%b), want 16", n, ok);
      end
      checks++;
      if (err_a !== 1'b1) begin
         failures++;
         $display("FAIL timeout_flag: error_timeout=%b, want 1", err_a);
      end
      ok = 1'b0;
      for (int i = 0; i < 30 && !ok; i++) begin
         @(negedge clk);
         if (inicio_a === 1'b1) ok = 1'b1;
      end
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL timeout_retry: no retry inicio within 30 cycles, want one");
      end
      limp_a = 1'b1;
      @(negedge clk);
      limp_a = 1'b0;
      checks++;
      if (err_a !== 1'b0) begin
         failures++;
         $display("FAIL clear_error: error_timeout=%b after limpiar_error, want 0", err_a);
      end
      limp_a = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 40 && !ok; i++) begin
         @(negedge clk);
         if (inicio_a === 1'b0) ok = 1'b1;
      end
      checks++;
      if (!ok || err_a !== 1'b1) begin
         failures++;
         $display("FAIL set_wins: error_timeout=%b at timeout with limpiar held (fell=%b), want 1", err_a, ok);
      end
      @(negedge clk);
      checks++;
      if (err_a !== 1'b0) begin
         failures++;
         $display("FAIL clear_after_set: error_timeout=%b, want 0", err_a);
      end
      limp_a = 1'b0;
      hab_a = 1'b0;
      responde_a = 1'b1;
      repeat (40) @(negedge clk);
   endtask

   task automatic test_perdidas();
      bit ok;
      hab_b = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 60 && !ok; i++) begin
         @(negedge clk);
         if (inicio_b === 1'b1) ok = 1'b1;
      end
      for (int c = 0; c < 5; c++) begin
         for (int i = 0; i < 100 && inicio_b === 1'b1; i++) @(negedge clk);
         if (inicio_b === 1'b1) ok = 1'b0;
         for (int i = 0; i < 100 && inicio_b === 1'b0; i++) @(negedge clk);
         if (inicio_b === 1'b0) ok = 1'b0;
      end
      checks++;
      if (!ok || perd_b !== 8'd5) begin
         failures++;
         $display("FAIL lost_ticks: contador_perdidas=%0d after 5 conversions (seq ok=%b), want 5", perd_b, ok);
      end
      checks++;
      if (err_b !== 1'b0) begin
         failures++;
         $display("FAIL slow_no_timeout: error_timeout=%b, want 0", err_b);
      end
      repeat (296 * 40) @(negedge clk);
      checks++;
      if (perd_b !== 8'd255) begin
         failures++;
         $display("FAIL lost_saturate: contador_perdidas=%0d after ~300 losses, want 255", perd_b);
      end
      hab_b = 1'b0;
   endtask

   task automatic test_reset_async();
      bit ok;
      hab_a = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 40 && !ok; i++) begin
         @(negedge clk);
         if (inicio_a === 1'b1) ok = 1'b1;
      end
      #1 rst_a = 1'b0;
      #1;
      checks++;
      if (!ok || inicio_a !== 1'b0 || ocup_a !== 1'b0) begin
         failures++;
         $display("FAIL async_reset: inicio=%b ocupado=%b without clock edge (reached SOLICITAR=%b), want 0 0",
                  inicio_a, ocup_a, ok);
      end
      @(negedge clk);
      rst_a = 1'b1;
      hab_a = 1'b0;
      repeat (10) @(negedge clk);
   endtask

   task automatic test_descarte();
      bit ok;
      int base;
      int exp_v;
      datos_a = '{7, 7, 4, 4, 4, 4};
      esperado_a.push_back(4);
      base = n_listo_a;
      hab_a = 1'b1;
      for (int i = 0; i < 200 && n_listo_a < base + 2; i++) @(negedge clk);
      for (int i = 0; i < 20 && ocup_a === 1'b1; i++) @(negedge clk);
      hab_a = 1'b0;
      repeat (5) @(negedge clk);
      hab_a = 1'b1;
      esperar_valido_a(400, ok);
      hab_a = 1'b0;
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL discard_wait: no promedio_valido within 400 cycles, want one");
      end else begin
         exp_v = esperado_a.pop_front();
         checks++;
         if (prom_a !== 4'(exp_v)) begin
            failures++;
            $display("FAIL discard_partial: promedio=%0d, want %0d", prom_a, exp_v);
         end
      end
      repeat (20) @(negedge clk);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_promedio();
      test_saturacion();
      test_timeout();
      test_perdidas();
      test_reset_async();
      test_descarte();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/adc_secuenciador.md
Name: adc_secuenciador

Overview:
- Sampling controller that sequences the serial-ADC interface block (inputs `inicio`, outputs `listo` and a 4-bit clean sample).
- Issues conversion requests at a programmable sample rate derived from clk100MHz and captures each sample on `listo`.
- Accumulates 2^N_PROM_LOG2 samples and delivers their truncated average with a one-cycle valid strobe.
- Sits between the ADC interface and downstream processing; flags timeouts and counts lost sample ticks.

Parameters:
- ANCHO_DATO, 4, sample width in bits.
- DIV_MUESTREO, 2268, clk100MHz cycles per sample tick (about 44.1 kHz).
- N_PROM_LOG2, 2, log2 of the number of samples averaged.
- TIMEOUT, 4096, maximum cycles spent in SOLICITAR waiting for `listo`.

Ports:
- clk100MHz  in  1  system clock, rising edge.
- reset  in  1  asynchronous reset, active-low (asserted at 0).
- habilitar  in  1  enables tick generation and the averaging run.
- listo  in  1  conversion-done level from the ADC interface.
- dato_adc  in  ANCHO_DATO  sample from the ADC interface; valid while `listo`=1.
- limpiar_error  in  1  synchronous clear of error_timeout.
- inicio  out  1  conversion request to the ADC interface (level).
- promedio  out  ANCHO_DATO  last averaged result.
- promedio_valido  out  1  one-cycle strobe marking a new promedio.
- ocupado  out  1  high whenever state is not REPOSO.
- error_timeout  out  1  sticky timeout flag.
- contador_perdidas  out  8  saturating count of lost ticks.

Behaviour:
- Reset (reset=0), asynchronous, applies immediately, including mid-operation:
  - inicio=0, promedio=0, promedio_valido=0, error_timeout=0, contador_perdidas=0.
  - state=REPOSO, so ocupado=0.
  - Accumulator, sample count, divider, timeout counter and listo_r all cleared.
- Tick divider: counts 0..DIV_MUESTREO-1 while habilitar=1, then wraps. `tick` is asserted for one cycle at the terminal count. While habilitar=0 the divider is held at 0.
- `listo` is registered into listo_r every cycle. listo_sub = listo & ~listo_r. Only the rising edge is acted on, so `listo` may be a level of any length.
- State machine:
  - REPOSO:
    - On tick, go to SOLICITAR.
    - If habilitar=0, the accumulator and sample count are cleared, discarding any partial average.
  - SOLICITAR:
    - inicio=1 (registered, high from the cycle after entry) and the timeout counter increments.
    - On listo_sub: acc <= acc + dato_adc, cnt <= cnt + 1, go to CERRAR.
    - Otherwise, when the timeout counter reaches TIMEOUT: set error_timeout, keep acc/cnt unchanged, go to REPOSO.
    - If listo_sub and timeout occur in the same cycle, listo_sub wins.
  - CERRAR (exactly one cycle):
    - inicio=0.
    - If cnt == 2^N_PROM_LOG2: promedio <= acc[ANCHO_DATO+N_PROM_LOG2-1 : N_PROM_LOG2] (truncation, no rounding), promedio_valido <= 1 for one cycle, acc <= 0, cnt <= 0.
    - Go to REPOSO.
- Latency: if listo is first sampled high at edge k, promedio/promedio_valido update at edge k+2.
- inicio deasserts at edge k+1.
- Accumulator width is ANCHO_DATO+N_PROM_LOG2, so overflow cannot occur.
- A tick seen while state != REPOSO, including the CERRAR cycle, is lost: contador_perdidas increments and saturates at 255.
- habilitar falling mid-conversion: the current SOLICITAR/CERRAR completes normally. The partial average is discarded on return to REPOSO.
- error_timeout is cleared only by limpiar_error=1 or reset. If a timeout set and limpiar_error coincide, set wins.

Decomposition:
- Shared package adc_defs: state encoding (REPOSO, SOLICITAR, CERRAR) and default constants (DIV_MUESTREO, TIMEOUT, ANCHO_DATO).
- One sub-module, divisor_muestreo: parameterised tick generator with enable.
- FSM, accumulator and counters stay in adc_secuenciador.

Test Plan:
All scenarios use DIV_MUESTREO=20, N_PROM_LOG2=2, TIMEOUT=16 unless noted.
1. Reset held for 5 cycles, then released with habilitar=0 -> all outputs 0; no inicio for 100 cycles.
2. habilitar=1; model answers each inicio with listo after 3 cycles, dato_adc = 8, 8, 9, 9 -> promedio=8 (34>>2), one promedio_valido pulse exactly 2 edges after the 4th listo edge, inicio low at edge+1.
3. dato_adc = 15 for four samples -> promedio=15, no overflow; a fifth sample starts a fresh accumulation.
4. Model never raises listo -> inicio high for 16 cycles, then 0, error_timeout=1. Next tick retries. Pulsing limpiar_error clears the flag.
5. TIMEOUT=64, model delays listo by 30 cycles -> contador_perdidas +1 per conversion. Forcing 300 losses shows saturation at 255.
6. reset=0 mid-SOLICITAR -> inicio drops with no clock edge. Separately, habilitar=0 after 2 samples, then re-enabled with samples 4, 4, 4, 4 -> promedio=4, confirming the partial average was discarded.
